// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the boot-time ROM loader.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
    localparam int         TIMEOUT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input, ROM write port and status outputs of the loader.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [7:0]            RX_DATA;
    logic                  RX_VALID;
    logic                  ROM_WE;
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [15:0]           ROM_DATA;
    logic                  CPU_RESET;
    logic                  LOADING;
    logic                  LOAD_DONE;
    logic                  LOAD_ERROR;
    logic [15:0]           WORD_COUNT;

    modport master (
        input  RX_DATA, RX_VALID,
        output ROM_WE, ROM_ADDR, ROM_DATA, CPU_RESET, LOADING, LOAD_DONE, LOAD_ERROR, WORD_COUNT
    );

    modport slave (
        output RX_DATA, RX_VALID,
        input  ROM_WE, ROM_ADDR, ROM_DATA, CPU_RESET, LOADING, LOAD_DONE, LOAD_ERROR, WORD_COUNT
    );
endinterface

// File: rtl/rom_loader_timeout.sv
// Inter-byte idle timer: down-counter reloaded on every byte and while disabled.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int               CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Terminal count lands exactly TIMEOUT_CYCLES clocks after the last byte strobe.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b)
            count <= RELOAD;
        else if (clear || !enable)
            count <= RELOAD;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign expired = enable && (count == '0);
endmodule

// File: rtl/rom_loader.sv
// Frame parser that writes 16-bit words into instruction ROM while holding the CPU in reset.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 15,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic         CLK_100MHz,
    input  logic         RESET_N,
    rom_loader_if.master bus
);
    // state   | meaning
    // IDLE    | CPU runs, waiting for sync
    // LEN_HI  | expecting length high byte
    // LEN_LO  | expecting length low byte, range check
    // DATA_HI | expecting word high byte
    // DATA_LO | expecting word low byte, ROM write next cycle
    // CHECK   | expecting checksum byte
    // ERROR   | failed load, CPU held in reset until next sync

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state, state_nxt;
    logic [7:0]            len_hi, data_hi, csum, csum_nxt;
    logic [15:0]           len, len_rx, index, index_inc;
    logic                  rom_we, load_done, is_sync, tmo_en, expired;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [15:0]           rom_data, word_count;

    assign is_sync   = bus.RX_VALID && (bus.RX_DATA == SYNC_BYTE);
    assign len_rx    = {len_hi, bus.RX_DATA};
    assign index_inc = index + 16'd1;
    assign csum_nxt  = csum + bus.RX_DATA;
    assign tmo_en    = (state != IDLE) && (state != ERROR);

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_sys (CLK_100MHz),
        .rst_b   (RESET_N),
        .enable  (tmo_en),
        .clear   (bus.RX_VALID),
        .expired (expired)
    );

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERROR: if (is_sync) state_nxt = LEN_HI;
            LEN_HI:      if (bus.RX_VALID) state_nxt = LEN_LO;
            LEN_LO: begin
                if (bus.RX_VALID) begin
                    if ({1'b0, len_rx} > MAX_WORDS) state_nxt = ERROR;
                    else if (len_rx == 16'd0)       state_nxt = CHECK;
                    else                            state_nxt = DATA_HI;
                end
            end
            DATA_HI:     if (bus.RX_VALID) state_nxt = DATA_LO;
            DATA_LO:     if (bus.RX_VALID) state_nxt = (index_inc == len) ? CHECK : DATA_HI;
            CHECK:       if (bus.RX_VALID) state_nxt = (csum_nxt == 8'h00) ? IDLE : ERROR;
            default:     state_nxt = IDLE;
        endcase
        // A byte arriving on the terminal count takes priority over the timeout.
        if (tmo_en && expired && !bus.RX_VALID)
            state_nxt = ERROR;
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            len_hi     <= '0;
            len        <= '0;
            data_hi    <= '0;
            csum       <= '0;
            index      <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            load_done  <= 1'b0;
            word_count <= '0;
        end else begin
            rom_we    <= 1'b0;
            load_done <= 1'b0;
            if (bus.RX_VALID) begin
                case (state)
                    IDLE, ERROR: begin
                        if (is_sync) begin
                            csum  <= '0;
                            index <= '0;
                        end
                    end
                    LEN_HI: begin
                        len_hi <= bus.RX_DATA;
                        csum   <= csum_nxt;
                    end
                    LEN_LO: begin
                        len  <= len_rx;
                        csum <= csum_nxt;
                    end
                    DATA_HI: begin
                        data_hi <= bus.RX_DATA;
                        csum    <= csum_nxt;
                    end
                    DATA_LO: begin
                        rom_we   <= 1'b1;
                        rom_addr <= index[ADDR_WIDTH-1:0];
                        rom_data <= {data_hi, bus.RX_DATA};
                        index    <= index_inc;
                        csum     <= csum_nxt;
                    end
                    CHECK: begin
                        if (csum_nxt == 8'h00) begin
                            load_done  <= 1'b1;
                            word_count <= len;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.LOADING    = 1'b0;
        bus.CPU_RESET  = 1'b0;
        bus.LOAD_ERROR = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
                bus.LOADING   = 1'b1;
                bus.CPU_RESET = 1'b1;
            end
            ERROR: begin
                bus.CPU_RESET  = 1'b1;
                bus.LOAD_ERROR = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ROM_WE     = rom_we;
    assign bus.ROM_ADDR   = rom_addr;
    assign bus.ROM_DATA   = rom_data;
    assign bus.LOAD_DONE  = load_done;
    assign bus.WORD_COUNT = word_count;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader; ROM writes are matched against a queue of expected writes.
module tb_rom_loader;
    localparam int ADDR_WIDTH     = 15;
    localparam int TIMEOUT_CYCLES = 100;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           data;
    } wr_t;

    logic CLK_100MHz = 1'b0;
    logic RESET_N    = 1'b0;
    int   checks     = 0;
    int   errors     = 0;
    wr_t  exp_q[$];

    rom_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus();

    rom_loader #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET_N    (RESET_N),
        .bus        (bus)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK_100MHz);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        @(negedge CLK_100MHz);
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input int addr);
        wr_t w;
        send_byte(hi);
        w.addr = ADDR_WIDTH'(addr);
        w.data = {hi, lo};
        exp_q.push_back(w);
        send_byte(lo);
        chk("we_latency", 32'(bus.ROM_WE), 1);
    endtask

    task automatic chk_status(input string tag, input logic loading, input logic cpu_reset,
                              input logic err, input logic done);
        chk({tag, "_loading"},   32'(bus.LOADING),    32'(loading));
        chk({tag, "_cpu_reset"}, 32'(bus.CPU_RESET),  32'(cpu_reset));
        chk({tag, "_error"},     32'(bus.LOAD_ERROR), 32'(err));
        chk({tag, "_done"},      32'(bus.LOAD_DONE),  32'(done));
    endtask

    // Every ROM write must match the oldest expected write.
    always @(negedge CLK_100MHz) begin
        if (RESET_N && bus.ROM_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected_addr", 32'(bus.ROM_ADDR), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(bus.ROM_ADDR), 32'(w.addr));
                chk("wr_data", 32'(bus.ROM_DATA), 32'(w.data));
            end
        end
    end

    initial begin
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;

        repeat (3) @(negedge CLK_100MHz);
        chk_status("reset", 0, 0, 0, 0);
        chk("reset_we", 32'(bus.ROM_WE), 0);
        chk("reset_wc", 32'(bus.WORD_COUNT), 0);
        RESET_N = 1'b1;

        // Non-sync bytes in IDLE are ignored.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk_status("noise", 0, 0, 0, 0);

        // Happy path, two words.
        send_byte(8'hA5);
        chk_status("sync", 1, 1, 0, 0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(8'h12, 8'h34, 0);
        send_word(8'hAB, 8'hCD, 1);
        chk_status("pre_chk", 1, 1, 0, 0);
        send_byte(8'h40);
        chk_status("good", 0, 0, 0, 1);
        chk("good_wc", 32'(bus.WORD_COUNT), 2);
        @(negedge CLK_100MHz);
        chk("done_pulse", 32'(bus.LOAD_DONE), 0);

        // Same frame with a bad checksum: writes still happen, CPU stays held.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(8'h12, 8'h34, 0);
        send_word(8'hAB, 8'hCD, 1);
        send_byte(8'h41);
        chk_status("bad_chk", 0, 1, 1, 0);
        chk("bad_chk_wc", 32'(bus.WORD_COUNT), 2);
        repeat (3) @(negedge CLK_100MHz);
        chk_status("err_sticky", 0, 1, 1, 0);

        // Recovery frame; sync byte value used as data must not resync.
        send_byte(8'hA5);
        chk_status("resync", 1, 1, 0, 0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(8'hA5, 8'hA5, 0);
        send_byte(8'hB5);
        chk_status("recover", 0, 0, 0, 1);
        chk("recover_wc", 32'(bus.WORD_COUNT), 1);

        // Oversize length: error on LEN_LO, following bytes never reach ROM.
        send_byte(8'hA5);
        send_byte(8'h80);
        send_byte(8'h01);
        chk_status("oversize", 0, 1, 1, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("oversize_no_we", 32'(bus.ROM_WE), 0);
        chk("oversize_wc", 32'(bus.WORD_COUNT), 1);

        // Maximum length is accepted; async reset between hi and lo aborts.
        send_byte(8'hA5);
        send_byte(8'h80);
        send_byte(8'h00);
        chk_status("max_len", 1, 1, 0, 0);
        send_byte(8'h12);
        #2 RESET_N = 1'b0;
        #1;
        chk_status("async_rst", 0, 0, 0, 0);
        chk("async_rst_we", 32'(bus.ROM_WE), 0);
        chk("async_rst_wc", 32'(bus.WORD_COUNT), 0);
        @(negedge CLK_100MHz);
        RESET_N = 1'b1;
        send_byte(8'h34);
        chk("post_rst_no_we", 32'(bus.ROM_WE), 0);
        chk_status("post_rst", 0, 0, 0, 0);

        // Empty frame.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        chk_status("empty_pre", 1, 1, 0, 0);
        send_byte(8'h00);
        chk_status("empty", 0, 0, 0, 1);
        chk("empty_wc", 32'(bus.WORD_COUNT), 0);

        // Timeout: silence after a hi byte errors exactly TIMEOUT_CYCLES clocks later.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TIMEOUT_CYCLES - 1) @(negedge CLK_100MHz);
        chk_status("tmo_edge_m1", 1, 1, 0, 0);
        @(negedge CLK_100MHz);
        chk_status("tmo_hit", 0, 1, 1, 0);

        // A byte landing on the terminal count is accepted.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TIMEOUT_CYCLES - 2) @(negedge CLK_100MHz);
        begin
            wr_t w;
            w.addr = '0;
            w.data = 16'h1234;
            exp_q.push_back(w);
        end
        send_byte(8'h34);
        chk("tmo_byte_we", 32'(bus.ROM_WE), 1);
        chk_status("tmo_byte", 1, 1, 0, 0);
        send_byte(8'hB9);
        chk_status("tmo_done", 0, 0, 0, 1);
        chk("tmo_wc", 32'(bus.WORD_COUNT), 1);

        repeat (2) @(negedge CLK_100MHz);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time program loader on the instruction side of the CPU.
- Consumes a byte stream from the UART receiver and assembles it into 16-bit instruction words.
- Writes those words into instruction ROM through its write port.
- Holds the CPU in reset for the whole load, then releases it so execution restarts at PC 0 with the new program.

Parameters:
- ADDR_WIDTH, 15, width of the ROM word address; the ROM holds 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 10_000_000, maximum idle clocks between bytes inside a frame (100 ms at 100 MHz).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLK_100MHz  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid. There is no backpressure, so the loader accepts every strobe.
- ROM_WE  out  1  one-cycle ROM write strobe.
- ROM_ADDR  out  ADDR_WIDTH  word address for the ROM write.
- ROM_DATA  out  16  instruction word for the ROM write.
- CPU_RESET  out  1  active-high, drives the CPU RESET input.
- LOADING  out  1  high while a frame is in progress.
- LOAD_DONE  out  1  one-cycle pulse on a successful load.
- LOAD_ERROR  out  1  sticky error flag.
- WORD_COUNT  out  16  length field of the last accepted frame.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - State is IDLE.
  - All outputs are 0, including CPU_RESET, so the CPU runs the existing ROM contents.
  - Counters are cleared.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N = {LEN_HI,LEN_LO} words sent big-endian (hi byte, then lo byte), then CHK.
- Checksum rule: the 8-bit sum of LEN_HI..last data byte, plus CHK, must equal 0 mod 256.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, ERROR.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - SYNC_BYTE moves to LEN_HI, sets LOADING=1 and CPU_RESET=1, clears LOAD_ERROR, the checksum and the word index.
- LEN_HI → LEN_LO → (N==0 ? CHECK : DATA_HI).
  - Both length bytes are added to the checksum.
  - If N > 2**ADDR_WIDTH, go to ERROR when LEN_LO is received.
- DATA_HI: latch the high byte and go to DATA_LO.
- DATA_LO:
  - In the cycle after the lo byte strobe: ROM_WE=1 for exactly one cycle, ROM_ADDR = word index, ROM_DATA = {hi, lo}.
  - Then increment the index.
  - If index+1 == N go to CHECK, else go to DATA_HI.
  - Write latency is 1 clock from the RX_VALID of the lo byte.
- CHECK:
  - Sum zero: go to IDLE, LOAD_DONE pulses 1 cycle, LOADING=0, CPU_RESET=0 in the same cycle as LOAD_DONE, WORD_COUNT=N.
  - Sum nonzero: go to ERROR.
- ERROR:
  - LOAD_ERROR=1, LOADING=0, CPU_RESET stays 1 so a partial program is never executed.
  - Only SYNC_BYTE leaves ERROR, and it restarts exactly as it does from IDLE.
- Timeout:
  - Counter runs in every state except IDLE and ERROR.
  - It clears on each RX_VALID.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
  - If RX_VALID coincides with the terminal count, the byte wins: it is processed and the counter clears.
- SYNC_BYTE appearing inside a frame is treated as data, with no resync.
- ROM_ADDR wraps are impossible because of the length check.
- RESET_N asserted mid-frame aborts to IDLE with CPU_RESET=0. ROM contents already written remain.
- Checksum is an 8-bit wrap-around adder. WORD_COUNT and the word index are 16-bit; the index is compared against N at full width.

Decomposition:
- Shared package:
  - State enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, ERROR.
  - Default SYNC_BYTE.
  - Default TIMEOUT_CYCLES.
- One sub-module, loader_timeout:
  - Inputs: enable, clear.
  - Output: expired.
  - Counter width is derived from TIMEOUT_CYCLES.
- The FSM, checksum and ROM write port live in rom_loader.

Test Plan:
- Happy path: A5 00 02 12 34 AB CD, then CHK=(-(0x00+0x02+0x12+0x34+0xAB+0xCD))&0xFF=0x40 → ROM_WE at addr 0 data 16'h1234, then addr 1 data 16'hABCD. LOAD_DONE pulse, CPU_RESET falls the same cycle, WORD_COUNT=2, LOAD_ERROR=0.
- Bad checksum: same frame with CHK=0x41 → both ROM writes occur, LOAD_ERROR=1, CPU_RESET stays 1. A new good frame then clears LOAD_ERROR and releases CPU_RESET.
- Oversize/empty:
  - LEN=16'h8001 with ADDR_WIDTH=15 → ERROR right after LEN_LO, no ROM_WE.
  - A5 00 00 00 → LOAD_DONE with zero writes.
- Timeout with TIMEOUT_CYCLES=100: send A5 00 01 12, then silence → LOAD_ERROR=1 at byte+100 cycles. A byte arriving exactly at cycle 100 instead is accepted, with no error.
- Idle noise and async reset:
  - Bytes 00 FF 5A in IDLE → no state change, CPU_RESET=0.
  - RESET_N pulsed low between DATA_HI and DATA_LO → all outputs 0 immediately and no ROM_WE.
